seq_detect_param: RTL



---
 rtl/seq_detect_param.sv | 92 +++++++++
 1 files changed

// File: rtl/seq_detect_param.sv
// seq_detect_param
//   Parametrised serial bit-pattern detector. One bit is sampled per enabled
//   cycle, MSB of PATTERN first. y pulses for one cycle when the last LEN
//   real bits equal PATTERN. Bits that come from reset are never counted.
//
// Parameters
//   LEN      pattern length in bits (2..32)
//   PATTERN  LEN-bit target; PATTERN[LEN-1] is received first
//   OVERLAP  1: a matched pattern's bits may seed the next match
//            0: history restarts after each match
//   CNT_W    width of match_cnt
//
// Ports
//   clk        clock, all state changes on posedge
//   clr        synchronous active-high reset, has priority over en
//   en         x is valid this cycle
//   x          serial input bit
//   y          registered one-cycle match pulse
//   match_cnt  saturating match count since clr
//
// Build option
//   SEQDET_MATCH_CNT_EN  when defined, match_cnt counts matches and saturates
//                        at 2^CNT_W-1; when undefined, match_cnt is tied to 0.
module seq_detect_param #(
    parameter int unsigned    LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1101,
    parameter bit             OVERLAP = 1'b1,
    parameter int unsigned    CNT_W   = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             x,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned   FW        = $clog2(LEN + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(LEN);
    localparam logic [FW-1:0] FILL_ARM  = FW'(LEN - 1);

    logic [LEN-1:0] hist;
    logic [LEN-1:0] hist_nxt;
    logic [FW-1:0]  fill;
    logic [FW-1:0]  fill_nxt;
    logic           match;

    // fill counts real bits in hist, so reset zeros cannot form a match:
    // with LEN-1 valid bits already held, the incoming bit completes LEN.
    always_comb begin
        hist_nxt = {hist[LEN-2:0], x};
        match    = en && (fill >= FILL_ARM) && (hist_nxt == PATTERN);
        if (match && !OVERLAP) begin
            fill_nxt = '0;
        end else if (fill == FILL_FULL) begin
            fill_nxt = fill;
        end else begin
            fill_nxt = fill + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            hist <= '0;
            fill <= '0;
            y    <= 1'b0;
        end else begin
            y <= match;
            if (en) begin
                hist <= hist_nxt;
                fill <= fill_nxt;
            end
        end
    end

`ifdef SEQDET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (match && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign match_cnt = cnt;
`else
    assign match_cnt = '0;
`endif

endmodule
